// File: rtl/rsm_pkg.sv
// rtl/rsm_pkg.sv - shared sequencer states, opcodes and instruction field positions
package rsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DISPATCH,
        ST_EXEC_START,
        ST_EXEC_WAIT,
        ST_HALT,
        ST_ERROR
    } seq_state_t;

    localparam int INSTR_W = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int OP_MSB  = 12;
    localparam int OP_LSB  = 11;

    localparam logic [2:0] OPC_HALT = 3'b111;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;

    function automatic logic [2:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/instr_seq_ctrl_if.sv
// rtl/instr_seq_ctrl_if.sv - instruction memory read port and datapath s/w handshake
interface instr_seq_ctrl_if import rsm_pkg::*; #(
    parameter int PC_W = 8
);
    logic               mem_req;
    logic [PC_W-1:0]    mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;
    logic               s;
    logic               w;

    modport master (
        output mem_req, mem_addr, s,
        input  mem_ack, mem_rdata, w
    );

    modport slave (
        input  mem_req, mem_addr, s,
        output mem_ack, mem_rdata, w
    );
endinterface

// File: rtl/seq_watchdog.sv
// rtl/seq_watchdog.sv - fetch watchdog; expire flags the last cycle before timeout
module seq_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count;

    // Count saturates at the expire value so a stalled enable never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = (count == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/instr_seq_ctrl.sv
// rtl/instr_seq_ctrl.sv - instruction sequencer: fetch into IR, start datapath, advance PC
module instr_seq_ctrl import rsm_pkg::*; #(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    instr_seq_ctrl_if.master   bus,
    output logic [INSTR_W-1:0] ir,
    output logic [PC_W-1:0]    pc,
    output logic               halted,
    output logic               err,
    output logic [15:0]        instr_cnt
);
    seq_state_t state, state_nxt;
    logic       load_ir;
    logic       wd_clear;
    logic       wd_enable;
    logic       wd_expire;

    seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expire  (wd_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An ack always beats the watchdog, and run is only sampled on leaving EXEC_WAIT.
    always_comb begin
        state_nxt = state;
        load_ir   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run && bus.w) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.mem_ack) begin
                    load_ir   = 1'b1;
                    state_nxt = (opcode_of(bus.mem_rdata) == OPC_HALT) ? ST_HALT : ST_DISPATCH;
                end else if (wd_expire) begin
                    state_nxt = ST_ERROR;
                end
            end
            ST_DISPATCH:   state_nxt = ST_EXEC_START;
            ST_EXEC_START: begin
                if (!bus.w) state_nxt = ST_EXEC_WAIT;
            end
            ST_EXEC_WAIT: begin
                if (bus.w) state_nxt = run ? ST_FETCH : ST_IDLE;
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= PC_W'(RESET_PC);
            ir        <= '0;
            instr_cnt <= '0;
        end else begin
            if (load_ir) ir <= bus.mem_rdata;
            if (state == ST_DISPATCH) begin
                pc <= pc + PC_W'(1);
                if (instr_cnt != 16'hFFFF) instr_cnt <= instr_cnt + 16'd1;
            end
        end
    end

    assign wd_clear     = (state != ST_FETCH) || bus.mem_ack;
    assign wd_enable    = (state == ST_FETCH);

    assign bus.mem_req  = (state == ST_FETCH);
    assign bus.mem_addr = pc;
    assign bus.s        = (state == ST_DISPATCH);
    assign halted       = (state == ST_HALT);
    assign err          = (state == ST_ERROR);
endmodule

// File: tb/tb_instr_seq_ctrl.sv
// tb/tb_instr_seq_ctrl.sv - directed self-checking bench for instr_seq_ctrl
`timescale 1ns/1ps
module tb_instr_seq_ctrl;
    import rsm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        run;
    logic        run2;
    int          tests_run = 0;
    int          tests_failed = 0;

    instr_seq_ctrl_if #(.PC_W(8)) bus ();
    instr_seq_ctrl_if #(.PC_W(2)) bus2 ();

    logic [15:0] ir, ir2, instr_cnt, instr_cnt2;
    logic [7:0]  pc;
    logic [1:0]  pc2;
    logic        halted, err, halted2, err2;

    instr_seq_ctrl #(.PC_W(8), .RESET_PC(0), .TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .bus(bus),
        .ir(ir), .pc(pc), .halted(halted), .err(err), .instr_cnt(instr_cnt)
    );

    instr_seq_ctrl #(.PC_W(2), .RESET_PC(0), .TIMEOUT(15)) dut2 (
        .clk(clk), .reset_n(reset_n), .run(run2), .bus(bus2),
        .ir(ir2), .pc(pc2), .halted(halted2), .err(err2), .instr_cnt(instr_cnt2)
    );

    // Memory with programmable latency and a datapath that drops w for w_busy cycles after s.
    logic [15:0] mem [256];
    logic [15:0] mem2 [4];
    int ack_wait = 0;
    int w_busy = 1;
    int w_busy2 = 1;
    int lat_cnt, busy, busy2;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) lat_cnt <= 0;
        else if (bus.mem_req && !bus.mem_ack) lat_cnt <= lat_cnt + 1;
        else lat_cnt <= 0;
    end
    assign bus.mem_ack   = bus.mem_req && (lat_cnt >= ack_wait);
    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) busy <= 0;
        else if (bus.s) busy <= w_busy;
        else if (busy != 0) busy <= busy - 1;
    end
    assign bus.w = (busy == 0);

    assign bus2.mem_ack   = bus2.mem_req;
    assign bus2.mem_rdata = mem2[bus2.mem_addr];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) busy2 <= 0;
        else if (bus2.s) busy2 <= w_busy2;
        else if (busy2 != 0) busy2 <= busy2 - 1;
    end
    assign bus2.w = (busy2 == 0);

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        run     = 1'b0;
        run2    = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        run = 1'b0;
        run2 = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
        tests_run++; if (bus.s !== 1'b0) begin tests_failed++; $display("FAIL reset_s: got %b expected 0", bus.s); end
        tests_run++; if (pc !== 8'h00) begin tests_failed++; $display("FAIL reset_pc: got %h expected 00", pc); end
        tests_run++; if (ir !== 16'h0000) begin tests_failed++; $display("FAIL reset_ir: got %h expected 0000", ir); end
        tests_run++; if (instr_cnt !== 16'h0000) begin tests_failed++; $display("FAIL reset_cnt: got %h expected 0000", instr_cnt); end
        tests_run++; if ({halted, err} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags: got %b expected 00", {halted, err}); end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++; if (bus.mem_req !== 1'b0) begin tests_failed++; $display("FAIL idle_no_run: got mem_req %b expected 0", bus.mem_req); end
    endtask

    task automatic test_zero_wait();
        bit found;
        fill_mem();
        mem[0] = 16'hD005;
        ack_wait = 0;
        w_busy = 1;
        do_reset();
        run = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.s) found = 1'b1;
        end
        tests_run++; if (!found) begin tests_failed++; $display("FAIL zw_s_seen: got none expected s pulse"); end
        tests_run++; if (ir !== 16'hD005) begin tests_failed++; $display("FAIL zw_ir: got %h expected d005", ir); end
        run = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.s !== 1'b0) begin tests_failed++; $display("FAIL zw_s_width: got %b expected 0", bus.s); end
        tests_run++; if (pc !== 8'h01) begin tests_failed++; $display("FAIL zw_pc: got %h expected 01", pc); end
        tests_run++; if (instr_cnt !== 16'h0001) begin tests_failed++; $display("FAIL zw_cnt: got %h expected 0001", instr_cnt); end
        repeat (8) @(negedge clk);
        tests_run++; if ({bus.mem_req, pc} !== {1'b0, 8'h01}) begin tests_failed++; $display("FAIL zw_stop_idle: got req %b pc %h expected 0 01", bus.mem_req, pc); end
    endtask

    task automatic test_latency();
        bit found;
        int req_cycles, addr_bad, gap, s_cnt;
        fill_mem();
        mem[0] = 16'hD005;
        ack_wait = 4;
        w_busy = 4;
        do_reset();
        run = 1'b1;
        found = 1'b0; req_cycles = 0; addr_bad = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                req_cycles++;
                if (bus.mem_addr !== 8'h00) addr_bad++;
            end
            if (bus.s) found = 1'b1;
        end
        tests_run++; if (!found) begin tests_failed++; $display("FAIL lat_s_seen: got none expected s pulse"); end
        tests_run++; if (req_cycles != 5) begin tests_failed++; $display("FAIL lat_req_cycles: got %0d expected 5", req_cycles); end
        tests_run++; if (addr_bad != 0) begin tests_failed++; $display("FAIL lat_addr_stable: got %0d bad cycles expected 0", addr_bad); end
        found = 1'b0; gap = 0; s_cnt = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            gap++;
            if (bus.s) s_cnt++;
            if (bus.mem_req) found = 1'b1;
        end
        tests_run++; if (!found) begin tests_failed++; $display("FAIL lat_refetch: got none expected second fetch"); end
        tests_run++; if (gap != 6) begin tests_failed++; $display("FAIL lat_refetch_gap: got %0d expected 6", gap); end
        tests_run++; if (s_cnt != 0) begin tests_failed++; $display("FAIL lat_extra_s: got %0d expected 0", s_cnt); end
        tests_run++; if (bus.mem_addr !== 8'h01) begin tests_failed++; $display("FAIL lat_next_addr: got %h expected 01", bus.mem_addr); end
        run = 1'b0;
    endtask

    task automatic test_halt();
        int s_cnt, req_cnt;
        fill_mem();
        mem[0] = 16'hD005;
        mem[1] = 16'hE000;
        ack_wait = 0;
        w_busy = 1;
        do_reset();
        run = 1'b1;
        s_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.s) s_cnt++;
        end
        tests_run++; if (s_cnt != 1) begin tests_failed++; $display("FAIL halt_s_cnt: got %0d expected 1", s_cnt); end
        tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("FAIL halt_flag: got %b expected 1", halted); end
        tests_run++; if (pc !== 8'h01) begin tests_failed++; $display("FAIL halt_pc: got %h expected 01", pc); end
        tests_run++; if (instr_cnt !== 16'h0001) begin tests_failed++; $display("FAIL halt_cnt: got %h expected 0001", instr_cnt); end
        tests_run++; if (ir !== 16'hE000) begin tests_failed++; $display("FAIL halt_ir: got %h expected e000", ir); end
        req_cnt = 0; s_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.mem_req) req_cnt++;
            if (bus.s) s_cnt++;
        end
        tests_run++; if (req_cnt + s_cnt != 0) begin tests_failed++; $display("FAIL halt_quiet: got %0d req %0d s expected 0 0", req_cnt, s_cnt); end
    endtask

    task automatic test_timeout();
        bit found;
        int cyc, req_cnt;
        fill_mem();
        ack_wait = 1000;
        w_busy = 1;
        do_reset();
        run = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (bus.mem_req) found = 1'b1;
        end
        tests_run++; if (!found) begin tests_failed++; $display("FAIL to_fetch_entry: got none expected mem_req"); end
        found = 1'b0; cyc = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            cyc++;
            if (err) found = 1'b1;
        end
        tests_run++; if (!found) begin tests_failed++; $display("FAIL to_err_seen: got none expected err"); end
        tests_run++; if (cyc != 15) begin tests_failed++; $display("FAIL to_err_cycle: got %0d expected 15", cyc); end
        req_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.mem_req) req_cnt++;
        end
        tests_run++; if ({err, req_cnt[3:0]} !== 5'b10000) begin tests_failed++; $display("FAIL to_err_sticky: got err %b req %0d expected 1 0", err, req_cnt); end

        ack_wait = 14;
        do_reset();
        run = 1'b1;
        found = 1'b0; cyc = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (bus.mem_req) cyc++;
            if (bus.s) found = 1'b1;
        end
        tests_run++; if (!found) begin tests_failed++; $display("FAIL to_late_ack_s: got none expected s pulse"); end
        tests_run++; if (cyc != 15) begin tests_failed++; $display("FAIL to_late_ack_len: got %0d expected 15", cyc); end
        run = 1'b0;
        repeat (10) @(negedge clk);
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL to_late_ack_err: got %b expected 0", err); end
        tests_run++; if (instr_cnt !== 16'h0001) begin tests_failed++; $display("FAIL to_late_ack_cnt: got %h expected 0001", instr_cnt); end
    endtask

    task automatic test_wrap_stop();
        logic [1:0] addrs [5];
        logic [1:0] exp_addr [5];
        int n, req_cnt;
        bit found;
        exp_addr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) mem2[i] = 16'hC000 | 16'(i);
        w_busy2 = 1;
        do_reset();
        run2 = 1'b1;
        n = 0;
        for (int k = 0; k < 80 && n < 5; k++) begin
            @(negedge clk);
            if (bus2.mem_req) begin
                addrs[n] = bus2.mem_addr;
                n++;
            end
        end
        tests_run++; if (n != 5) begin tests_failed++; $display("FAIL wrap_fetches: got %0d expected 5", n); end
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (bus2.s) found = 1'b1;
        end
        @(negedge clk);
        run2 = 1'b0;
        for (int i = 0; i < n; i++) begin
            tests_run++; if (addrs[i] !== exp_addr[i]) begin tests_failed++; $display("FAIL wrap_addr%0d: got %0d expected %0d", i, addrs[i], exp_addr[i]); end
        end
        req_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus2.mem_req) req_cnt++;
        end
        tests_run++; if (req_cnt != 0) begin tests_failed++; $display("FAIL wrap_stop: got %0d fetches expected 0", req_cnt); end
        tests_run++; if (pc2 !== 2'd1) begin tests_failed++; $display("FAIL wrap_pc: got %0d expected 1", pc2); end
        tests_run++; if (instr_cnt2 !== 16'd5) begin tests_failed++; $display("FAIL wrap_cnt: got %0d expected 5", instr_cnt2); end
    endtask

    task automatic test_async_reset();
        bit found;
        fill_mem();
        mem[0] = 16'hD005;
        ack_wait = 0;
        w_busy = 6;
        do_reset();
        run = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.s) found = 1'b1;
        end
        repeat (2) @(negedge clk);
        tests_run++; if ({found, bus.w, pc} !== {1'b1, 1'b0, 8'h01}) begin tests_failed++; $display("FAIL ar_pre: got s %b w %b pc %h expected 1 0 01", found, bus.w, pc); end
        #2 reset_n = 1'b0;
        #1;
        tests_run++; if (pc !== 8'h00) begin tests_failed++; $display("FAIL ar_pc: got %h expected 00", pc); end
        tests_run++; if ({ir, instr_cnt} !== 32'h0) begin tests_failed++; $display("FAIL ar_regs: got %h %h expected 0 0", ir, instr_cnt); end
        tests_run++; if ({bus.mem_req, bus.s, halted, err} !== 4'b0000) begin tests_failed++; $display("FAIL ar_strobes: got %b expected 0000", {bus.mem_req, bus.s, halted, err}); end
        @(negedge clk);
        reset_n = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (bus.mem_req) found = 1'b1;
        end
        tests_run++; if (!found) begin tests_failed++; $display("FAIL ar_restart: got none expected fetch"); end
        tests_run++; if (bus.mem_addr !== 8'h00) begin tests_failed++; $display("FAIL ar_restart_addr: got %h expected 00", bus.mem_addr); end
        run = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        run = 1'b0;
        run2 = 1'b0;
        fill_mem();
        for (int i = 0; i < 4; i++) mem2[i] = 16'hC000;
        test_reset();
        test_zero_wait();
        test_latency();
        test_halt();
        test_timeout();
        test_wrap_stop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/instr_seq_ctrl.md
Name: instr_seq_ctrl

Overview:
- Top-level instruction sequencer for the RISC datapath controller (the datapath FSM with s/w handshake).
- Fetches 16-bit instructions from instruction memory at the PC and holds them in the instruction register (IR). Fires a one-cycle start pulse to the datapath FSM, waits for it to return to its WAIT state, then advances the PC.
- Detects HALT and runs a memory-timeout watchdog.

Parameters:
- PC_W, 8, PC / memory address width; PC wraps modulo 2^PC_W.
- RESET_PC, 0, PC value loaded on reset.
- TIMEOUT, 15, maximum cycles mem_ack may stay low during a fetch before error.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = sequencer may fetch/execute
- mem_ack  in  1  memory read data valid this cycle
- mem_rdata  in  16  instruction word, valid when mem_ack=1
- w  in  1  datapath FSM idle (in its WAIT state)
- mem_req  out  1  read request, held until mem_ack
- mem_addr  out  PC_W  read address (= pc while mem_req=1)
- ir  out  16  instruction register; opcode=ir[15:13], op=ir[12:11]
- s  out  1  one-cycle start pulse to datapath FSM
- pc  out  PC_W  program counter
- halted  out  1  HALT instruction reached (sticky)
- err  out  1  fetch timeout (sticky)
- instr_cnt  out  16  instructions dispatched, saturating at 16'hFFFF

Behaviour:
- Reset (reset_n=0, async):
  - State IDLE; pc=RESET_PC; ir=0; instr_cnt=0.
  - mem_req=0, s=0, halted=0, err=0; watchdog count=0.
  - Reset mid-fetch or mid-execute aborts immediately; no partial PC update.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
- States: IDLE, FETCH, DISPATCH, EXEC_START, EXEC_WAIT, HALT, ERROR.
- IDLE: all strobes 0. Go to FETCH when run=1 && w=1.
- FETCH:
  - mem_req=1, mem_addr=pc, watchdog increments each cycle.
  - mem_ack=1 (same-cycle ack allowed):
    - ir<=mem_rdata; watchdog clears.
    - If mem_rdata[15:13]==3'b111, go to HALT.
    - Otherwise go to DISPATCH.
  - mem_ack=0 with watchdog==TIMEOUT-1: go to ERROR. Minimum fetch is 1 cycle.
- DISPATCH (exactly 1 cycle):
  - s=1.
  - pc<=pc+1, wrapping from 2^PC_W-1 to 0.
  - instr_cnt<=instr_cnt+1 unless already 16'hFFFF.
  - Go to EXEC_START.
- EXEC_START: wait for w=0 (datapath left WAIT), then go to EXEC_WAIT. w normally falls 1 cycle after s.
- EXEC_WAIT: wait for w=1 (instruction retired).
  - run=1: go to FETCH.
  - run=0: go to IDLE.
- run deasserted during FETCH/DISPATCH/EXEC_*: the current instruction completes; the stop takes effect only at the EXEC_WAIT exit.
- HALT:
  - halted=1; pc is not incremented (points at the HALT word).
  - s is never asserted. Exit only by reset.
- ERROR:
  - err=1, mem_req=0. Exit only by reset.
- Simultaneous events:
  - mem_ack on the timeout cycle: the ack wins; no error.
  - run=0 on the cycle mem_ack arrives: the fetch still completes.
- s is high for exactly one cycle per dispatched instruction.
- Throughput: FETCH(1 cycle min) + DISPATCH(1) + EXEC_START(≥1) + EXEC_WAIT(≥1).

Decomposition:
- Shared package rsm_pkg:
  - Sequencer state enum.
  - Opcode constants, including OPC_HALT=3'b111 and the existing 3'b110 (MOV) and 3'b101 (ALU).
  - Instruction field slice indices.
  - The controller and the datapath FSM both import it.
- One sub-module, seq_watchdog: counter with clear/enable/expire, parameterised by TIMEOUT.

Test Plan:
- Reset and zero-wait fetch:
  - Stimulus: reset_n pulse, run=1, w=1, mem_ack tied to mem_req, word 16'hD005 at addr 0.
  - Response: ir=16'hD005; s high 1 cycle; pc=1; instr_cnt=1.
- Variable latency:
  - Stimulus: mem_ack after 5 cycles, datapath model drops w for 4 cycles.
  - Response: mem_addr stable all 5 cycles; one s pulse; next fetch at addr 1 only after w returns 1.
- HALT:
  - Stimulus: program 16'hD005, 16'hE000 (opcode 111).
  - Response: halted=1; pc=1; instr_cnt=1; no further mem_req or s, even with run=1.
- Timeout:
  - Stimulus: mem_ack held 0.
  - Response: err=1 exactly TIMEOUT cycles after FETCH entry; mem_req=0 afterwards.
  - Variant: ack on cycle TIMEOUT-1 gives no error.
- Wrap and stop:
  - Stimulus: PC_W=2, 5 non-halt instructions, then run=0 during the 5th EXEC_START.
  - Response: addresses 0,1,2,3,0; sequencer returns to IDLE after the 5th retires; pc=1.
- Async reset mid-execute:
  - Stimulus: reset_n=0 during EXEC_WAIT.
  - Response: outputs go to reset values before the next clk edge; the sequencer restarts at RESET_PC when run=1.
